// File: rtl/am2909_seq_ctl.sv
// Next-address control for cascaded Am2909 slices: decodes the microinstruction
// sequence field into sequencer controls and tracks loop-counter and stack depth.
module am2909_seq_ctl #(
    parameter int CNT_W       = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic             CP,
    input  logic             RST,
    input  logic [3:0]       I,
    input  logic             CCEN,
    input  logic             CC,
    input  logic [CNT_W-1:0] CNT_D,
    output logic [1:0]       S,
    output logic             FE,
    output logic             PUP,
    output logic             ZERO,
    output logic             RE,
    output logic             OE,
    output logic             CNT_ZERO,
    output logic             FULL,
    output logic             EMPTY,
    output logic             OVF,
    output logic             UNF
);
    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam logic [DW-1:0] DMAX = DW'(STACK_DEPTH);

    localparam logic [1:0] SRC_UPC = 2'b00;
    localparam logic [1:0] SRC_AR  = 2'b01;
    localparam logic [1:0] SRC_STK = 2'b10;
    localparam logic [1:0] SRC_D   = 2'b11;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;

    logic       pass, cnt_nz;
    logic       push, pop, load, dec, clr;
    logic [1:0] s_dec;
    logic       zero_dec, re_dec;

    assign pass     = ~CCEN | CC;
    assign cnt_nz   = |cnt_q;
    assign CNT_ZERO = ~cnt_nz;
    assign FULL     = (depth_q == DMAX);
    assign EMPTY    = (depth_q == '0);
    assign OVF      = ovf_q;
    assign UNF      = unf_q;
    assign OE       = 1'b0;

    always_comb begin
        s_dec    = SRC_UPC;
        zero_dec = 1'b1;
        re_dec   = 1'b1;
        push     = 1'b0;
        pop      = 1'b0;
        load     = 1'b0;
        dec      = 1'b0;
        clr      = 1'b0;
        unique case (I)
            4'd0:  begin zero_dec = 1'b0; clr = 1'b1; end
            4'd2:  s_dec = SRC_D;
            4'd3:  if (pass) s_dec = SRC_D;
            4'd4:  if (pass) begin s_dec = SRC_D; push = 1'b1; end
            4'd5:  if (pass) begin s_dec = SRC_STK; pop = 1'b1; end
            4'd6:  load = 1'b1;
            4'd7:  if (cnt_nz) begin s_dec = SRC_D; dec = 1'b1; end
            4'd8:  begin push = 1'b1; load = pass; end
            4'd9:  if (cnt_nz) begin s_dec = SRC_STK; dec = 1'b1; end
                   else pop = 1'b1;
            4'd10: re_dec = 1'b0;
            4'd11: if (pass) s_dec = SRC_AR;
            default: ;
        endcase
    end

    // A pop at EMPTY keeps FE high so the sequencer's stack pointer is not disturbed.
    always_comb begin
        S    = s_dec;
        FE   = ~(push | (pop & ~EMPTY));
        PUP  = push;
        ZERO = zero_dec;
        RE   = re_dec;
        if (RST) begin
            S    = SRC_UPC;
            FE   = 1'b1;
            PUP  = 1'b0;
            ZERO = 1'b0;
            RE   = 1'b1;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (load)     cnt_d = CNT_D;
        else if (dec) cnt_d = cnt_q - 1'b1;
        if (clr) depth_d = '0;
        else if (push) begin
            if (FULL) ovf_d = 1'b1;
            else      depth_d = depth_q + 1'b1;
        end else if (pop) begin
            if (EMPTY) unf_d = 1'b1;
            else       depth_d = depth_q - 1'b1;
        end
    end

    always_ff @(posedge CP or posedge RST) begin
        if (RST) begin
            cnt_q   <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end
endmodule

// File: tb/tb_am2909_seq_ctl.sv
// Bench for am2909_seq_ctl: directed microinstruction sequences, a per-cycle
// behavioural model comparison, and literal spot checks.
module tb_am2909_seq_ctl;
    logic       CP = 1'b0;
    logic       RST;
    logic [3:0] I;
    logic       CCEN, CC;
    logic [7:0] CNT_D;
    logic [1:0] S;
    logic       FE, PUP, ZERO, RE, OE, CNT_ZERO, FULL, EMPTY, OVF, UNF;

    int checks = 0;
    int failures = 0;

    am2909_seq_ctl #(.CNT_W(8), .STACK_DEPTH(4)) dut (
        .CP(CP), .RST(RST), .I(I), .CCEN(CCEN), .CC(CC), .CNT_D(CNT_D),
        .S(S), .FE(FE), .PUP(PUP), .ZERO(ZERO), .RE(RE), .OE(OE),
        .CNT_ZERO(CNT_ZERO), .FULL(FULL), .EMPTY(EMPTY), .OVF(OVF), .UNF(UNF)
    );

    always #5 CP = ~CP;

    // Model state: loop count and stack occupancy as plain integers.
    int m_cnt = 0, m_dep = 0;
    bit m_ovf = 0, m_unf = 0;

    function automatic bit m_pass();
        return !CCEN || CC;
    endfunction

    function automatic bit m_push();
        return (I == 4 && m_pass()) || I == 8;
    endfunction

    function automatic bit m_pop();
        return (I == 5 && m_pass()) || (I == 9 && m_cnt == 0);
    endfunction

    always @(posedge CP or posedge RST) begin
        if (RST) begin
            m_cnt = 0; m_dep = 0; m_ovf = 0; m_unf = 0;
        end else begin
            if (I == 0) m_dep = 0;
            else if (m_push()) begin
                if (m_dep == 4) m_ovf = 1; else m_dep++;
            end else if (m_pop()) begin
                if (m_dep == 0) m_unf = 1; else m_dep--;
            end
            if (I == 6 || (I == 8 && m_pass())) m_cnt = CNT_D;
            else if ((I == 7 || I == 9) && m_cnt > 0) m_cnt--;
        end
    end

    function automatic logic [11:0] m_outs();
        int  s;
        bit  fe, pup, zero, re;
        case (I)
            2:  s = 3;
            3:  s = m_pass() ? 3 : 0;
            4:  s = m_pass() ? 3 : 0;
            5:  s = m_pass() ? 2 : 0;
            7:  s = (m_cnt != 0) ? 3 : 0;
            9:  s = (m_cnt != 0) ? 2 : 0;
            11: s = m_pass() ? 1 : 0;
            default: s = 0;
        endcase
        pup  = m_push();
        fe   = !(m_push() || (m_pop() && m_dep > 0));
        zero = (I != 0);
        re   = (I != 10);
        if (RST) begin
            s = 0; fe = 1; pup = 0; zero = 0; re = 1;
        end
        return {2'(s), fe, pup, zero, re, 1'b0, m_cnt == 0, m_dep == 4, m_dep == 0,
                m_ovf, m_unf};
    endfunction

    always @(negedge CP) begin
        logic [11:0] act, exp;
        act = {S, FE, PUP, ZERO, RE, OE, CNT_ZERO, FULL, EMPTY, OVF, UNF};
        exp = m_outs();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL model I=%0d t=%0t got=%b expected=%b", I, $time, act, exp);
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drv(input int i, input bit ccen, input bit cc, input int d);
        @(posedge CP);
        #1;
        I = 4'(i); CCEN = ccen; CC = cc; CNT_D = 8'(d);
        @(negedge CP);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; I = 4'd3; CCEN = 1'b1; CC = 1'b1; CNT_D = 8'd0;
        @(negedge CP);
        lit("rst_S", S, 0); lit("rst_FE", FE, 1); lit("rst_ZERO", ZERO, 0);
        lit("rst_EMPTY", EMPTY, 1); lit("rst_CNTZ", CNT_ZERO, 1);
        @(posedge CP); #1 RST = 1'b0;
        @(negedge CP);
        lit("rel_S", S, 3);

        // Calls fill the stack, the fifth overflows
        for (int k = 0; k < 4; k++) begin
            drv(4, 1, 1, 0);
            lit("cjs_FE", FE, 0); lit("cjs_PUP", PUP, 1);
        end
        drv(4, 1, 1, 0);
        lit("full4", FULL, 1); lit("ovf_pre", OVF, 0);
        drv(1, 0, 0, 0);
        lit("ovf", OVF, 1); lit("full5", FULL, 1);

        // Returns, down to underflow
        drv(5, 1, 0, 0);
        lit("crtn_f_S", S, 0); lit("crtn_f_FE", FE, 1);
        for (int k = 0; k < 4; k++) begin
            drv(5, 1, 1, 0);
            lit("crtn_S", S, 2); lit("crtn_FE", FE, 0); lit("crtn_PUP", PUP, 0);
        end
        drv(5, 1, 1, 0);
        lit("unf_EMPTY", EMPTY, 1); lit("unf_FE", FE, 1); lit("unf_S", S, 2);
        drv(1, 0, 0, 0);
        lit("unf", UNF, 1);

        // Counted loop
        drv(6, 0, 0, 3);
        for (int k = 0; k < 3; k++) begin
            drv(7, 0, 0, 0);
            lit("rpct_S", S, 3);
        end
        drv(7, 0, 0, 0);
        lit("rpct_end_S", S, 0); lit("rpct_CNTZ", CNT_ZERO, 1);

        // PUSH with counter load, then RFCT
        drv(8, 0, 0, 2);
        lit("push_FE", FE, 0); lit("push_PUP", PUP, 1); lit("push_S", S, 0);
        for (int k = 0; k < 2; k++) begin
            drv(9, 0, 0, 0);
            lit("rfct_S", S, 2); lit("rfct_FE", FE, 1);
        end
        drv(9, 0, 0, 0);
        lit("rfct_end_S", S, 0); lit("rfct_end_FE", FE, 0); lit("rfct_end_PUP", PUP, 0);
        drv(1, 0, 0, 0);
        lit("rfct_EMPTY", EMPTY, 1);

        // JZ after two pushes, then LDAR
        drv(4, 0, 0, 0);
        drv(4, 0, 0, 0);
        drv(0, 0, 0, 0);
        lit("jz_ZERO", ZERO, 0); lit("jz_EMPTY_pre", EMPTY, 0);
        drv(10, 0, 0, 0);
        lit("jz_EMPTY", EMPTY, 1); lit("ldar_RE", RE, 0); lit("ldar_S", S, 0);

        // CJAR, JMAP, spare codes, failed CJS
        drv(11, 1, 1, 0); lit("cjar_p", S, 1);
        drv(11, 1, 0, 0); lit("cjar_f", S, 0);
        drv(2, 1, 0, 0);  lit("jmap", S, 3);
        drv(3, 1, 0, 0);  lit("cjp_f", S, 0);
        for (int k = 12; k < 16; k++) begin
            drv(k, 1, 1, 0);
            lit("spare_S", S, 0); lit("spare_FE", FE, 1);
        end
        drv(4, 1, 0, 0); lit("cjs_f_FE", FE, 1);

        // Mid-cycle async reset clears sticky flags and forces outputs
        drv(4, 1, 1, 0);
        #1 RST = 1'b1;
        #1;
        lit("arst_S", S, 0); lit("arst_FE", FE, 1); lit("arst_ZERO", ZERO, 0);
        lit("arst_UNF", UNF, 0); lit("arst_EMPTY", EMPTY, 1);
        @(posedge CP); #1 RST = 1'b0;
        @(negedge CP);
        lit("rel2_FE", FE, 0); lit("rel2_S", S, 3);
        drv(1, 0, 0, 0);
        lit("rel2_dep", EMPTY, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
